cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Complete-stage arbiter downstream of the execute FUs (ALU, mult, ld/st).
//  Each cycle, picks one FU with done asserted using round-robin priority and
//  returns a one-hot complete_en to that FU. Registers the winner's result
//  onto the CDB for the ROB, RS wakeup and regfile write. Squashes on branch recovery.
// PARAMETERS
//  FU_NUM      4    number of FU completion ports; any value >=2
//  XLEN        32   result width (=`XLEN)
//  PREG_IDX_W  6    physical tag width (=$clog2(`PREG_NUMBER))
//  STAT_W      32   width of each statistics counter (CDB_STATS_EN only)
// PORTS
//  clk                 in   1                  clock, rising edge
//  reset               in   1                  synchronous, active-high
//  fu_done_i           in   FU_NUM             FU holds a finished result
//  fu_dest_reg_i       in   FU_NUM*PREG_IDX_W  per-FU destination tag
//  fu_dest_reg_sel_i   in   FU_NUM*DEST_REG_SEL per-FU dest select (DEST_RD/DEST_NONE)
//  fu_result_i         in   FU_NUM*XLEN        per-FU result
//  cdb_stall_i         in   1                  ROB/regfile cannot accept; grant nothing
//  branch_recover_i    in   2                  bit0=1: squash
//  fu_complete_en_o    out  FU_NUM             one-hot (or zero) grant, combinational
//  cdb_valid_o         out  1                  registered broadcast valid
//  cdb_tag_o           out  PREG_IDX_W         registered broadcast tag
//  cdb_value_o         out  XLEN               registered broadcast value
//  cdb_wr_en_o         out  1                  registered regfile write (valid & DEST_RD)
//  grant_cnt_o         out  FU_NUM*STAT_W      per-FU grant counts (CDB_STATS_EN only)
//  conflict_cnt_o      out  STAT_W             contention cycles (CDB_STATS_EN only)
// BEHAVIOUR
//  - Reset: rr_ptr=0; cdb_valid_o=0, cdb_tag_o=0, cdb_value_o=0, cdb_wr_en_o=0;
//    all counters 0. fu_complete_en_o=0 while reset is high.
//  - req = fu_done_i & {FU_NUM{~cdb_stall_i & ~branch_recover_i[0]}}.
//  - Grant: first set bit of req searching rr_ptr, rr_ptr+1, ... wrapping at FU_NUM-1->0.
//    fu_complete_en_o = one-hot of the winner, same cycle as fu_done_i. Zero if req==0.
//  - rr_ptr: on grant g, rr_ptr <= (g==FU_NUM-1) ? 0 : g+1. Holds otherwise.
//    Explicit compare; FU_NUM need not be a power of two.
//  - CDB register, loaded every cycle:
//    - on grant: valid<=1, tag<=fu_dest_reg_i[g], value<=fu_result_i[g],
//      wr_en<=(fu_dest_reg_sel_i[g]==DEST_RD).
//    - no grant: valid<=0, wr_en<=0, tag and value hold.
//    Latency is 1 cycle from grant to broadcast.
//  - DEST_NONE winner (store/branch): broadcast valid=1 with wr_en=0 so the ROB marks
//    completion.
//  - branch_recover_i[0]=1: no grant that cycle. Next cycle valid=0 and wr_en=0, so
//    any in-flight broadcast is dropped. rr_ptr holds.
//  - cdb_stall_i=1: no grant, valid<=0, rr_ptr holds. FUs keep done asserted.
//  - Starvation bound: a continuously done FU is granted within FU_NUM
//    non-stalled cycles.
//  - Reset has priority over all inputs; reset mid-broadcast clears valid next edge.
// CONFIGURATION
//  CDB_STATS_EN defined:
//    - grant_cnt_o[i] += 1 per grant to FU i.
//    - conflict_cnt_o += 1 per cycle with popcount(req)>=2.
//    - Counters wrap modulo 2^STAT_W, clear only on reset, not on branch recovery.
//  CDB_STATS_EN undefined: counters and both ports absent; grant/CDB behaviour identical.
// STRUCTURE
//  - Shared package (sys_defs): CDB_PACKET struct {valid, tag, value, wr_en}; reuse
//    DEST_REG_SEL; `PREG_NUMBER / `XLEN supply defaults.
//  - Sub-module rr_arbiter #(N): req, ptr -> one-hot gnt, gnt_idx, any_gnt; purely
//    combinational. rr_ptr and the CDB register stay in cdb_arbiter.
// TESTING
//  1. After reset, done=4'b0101, FU0 tag 5 val 0x11 DEST_RD
//     -> complete_en=0001; next cycle valid=1, tag=5, value=0x11, wr_en=1; rr_ptr=1.
//  2. done=4'b1111 held 5 cycles, no stall
//     -> grants 0001,0010,0100,1000,0001 (assuming rr_ptr=0 at start);
//        one broadcast per cycle.
//  3. rr_ptr=3, done=4'b1001 -> grant FU3; then rr_ptr=0 -> grant FU0 (wrap-around).
//  4. FU2 done, DEST_NONE, tag 0 -> complete_en=0100; next cycle valid=1, wr_en=0.
//  5. done=4'b0010 with branch_recover_i=2'b01 -> complete_en=0, next valid=0, rr_ptr
//     unchanged; with cdb_stall_i=1 instead -> same, done still high, granted once
//     stall drops.
//  6. CDB_STATS_EN: 10 cycles of done=4'b0011 -> grant_cnt FU0=5, FU1=5, conflict_cnt=10;
//     assert reset -> all 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the complete stage: destination select, CDB packet and
// the `XLEN / `PREG_NUMBER defaults used when the core has not supplied them.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PREG_NUMBER
`define PREG_NUMBER 64
`endif

package cdb_arbiter_pkg;

  localparam int XLEN_DEF       = `XLEN;
  localparam int PREG_IDX_W_DEF = $clog2(`PREG_NUMBER);

  typedef enum logic [1:0] {
    DEST_RD   = 2'h0,
    DEST_NONE = 2'h1
  } DEST_REG_SEL;

  localparam int DEST_SEL_W = $bits(DEST_REG_SEL);

  typedef struct packed {
    logic                      valid;
    logic [PREG_IDX_W_DEF-1:0] tag;
    logic [XLEN_DEF-1:0]       value;
    logic                      wr_en;
  } CDB_PACKET;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping
// at N-1 back to 0. Works for any N >= 2, not only powers of two.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_gnt_o
);

  always_comb begin
    int idx;
    logic [IDX_W-1:0] sel;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_gnt_o = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      sel = IDX_W'(idx);
      if (!any_gnt_o && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        gnt_idx_o  = sel;
        any_gnt_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Complete-stage arbiter: grants one done FU per cycle round-robin and registers
// its result onto the CDB. Optional statistics counters under CDB_STATS_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FU_NUM     = 4,
  parameter int XLEN       = XLEN_DEF,
  parameter int PREG_IDX_W = PREG_IDX_W_DEF
`ifdef CDB_STATS_EN
  , parameter int STAT_W   = 32
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [FU_NUM-1:0]              fu_done_i,
  input  logic [FU_NUM*PREG_IDX_W-1:0]   fu_dest_reg_i,
  input  logic [FU_NUM*DEST_SEL_W-1:0]   fu_dest_reg_sel_i,
  input  logic [FU_NUM*XLEN-1:0]         fu_result_i,
  input  logic                           cdb_stall_i,
  input  logic [1:0]                     branch_recover_i,
  output logic [FU_NUM-1:0]              fu_complete_en_o,
  output logic                           cdb_valid_o,
  output logic [PREG_IDX_W-1:0]          cdb_tag_o,
  output logic [XLEN-1:0]                cdb_value_o,
  output logic                           cdb_wr_en_o
`ifdef CDB_STATS_EN
  , output logic [FU_NUM*STAT_W-1:0]     grant_cnt_o,
  output logic [STAT_W-1:0]              conflict_cnt_o
`endif
);

  localparam int IDX_W = $clog2(FU_NUM);

  logic [FU_NUM-1:0] req;
  logic [FU_NUM-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              any_gnt;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  CDB_PACKET         cdb_q, cdb_d;
  logic              unused_recover;

  assign unused_recover = branch_recover_i[1];

  // Reset, stall and recovery all block arbitration in the same cycle.
  assign req = fu_done_i & {FU_NUM{~cdb_stall_i & ~branch_recover_i[0] & ~reset}};

  rr_arbiter #(.N(FU_NUM), .IDX_W(IDX_W)) u_rr (
    .req_i     (req),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_gnt_o (any_gnt)
  );

  assign fu_complete_en_o = gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_gnt)
      rr_ptr_d = (gnt_idx == IDX_W'(FU_NUM - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Tag and value hold when idle so the bus only toggles on real broadcasts.
  always_comb begin
    cdb_d       = cdb_q;
    cdb_d.valid = 1'b0;
    cdb_d.wr_en = 1'b0;
    for (int i = 0; i < FU_NUM; i++) begin
      if (any_gnt && gnt_idx == IDX_W'(i)) begin
        cdb_d.valid = 1'b1;
        cdb_d.tag   = fu_dest_reg_i[i*PREG_IDX_W +: PREG_IDX_W];
        cdb_d.value = fu_result_i[i*XLEN +: XLEN];
        cdb_d.wr_en = (fu_dest_reg_sel_i[i*DEST_SEL_W +: DEST_SEL_W] == DEST_RD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign cdb_valid_o = cdb_q.valid;
  assign cdb_tag_o   = cdb_q.tag;
  assign cdb_value_o = cdb_q.value;
  assign cdb_wr_en_o = cdb_q.wr_en;

`ifdef CDB_STATS_EN
  logic [STAT_W-1:0] grant_cnt_q [FU_NUM];
  logic [STAT_W-1:0] conflict_cnt_q;

  // Counters survive branch recovery; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FU_NUM; i++) grant_cnt_q[i] <= '0;
      conflict_cnt_q <= '0;
    end else begin
      for (int i = 0; i < FU_NUM; i++)
        if (gnt[i]) grant_cnt_q[i] <= grant_cnt_q[i] + 1'b1;
      if ($countones(req) >= 2) conflict_cnt_q <= conflict_cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < FU_NUM; g++) begin : g_cnt_out
    assign grant_cnt_o[g*STAT_W +: STAT_W] = grant_cnt_q[g];
  end
  assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter (4 FUs) plus hand-written
// sequences for fairness, reset mid-broadcast and the CDB_STATS_EN counters.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int FU_NUM = 4;
  localparam int XLEN   = 32;
  localparam int PW     = 6;
  localparam int STAT_W = 32;

  logic                         clk;
  logic                         reset;
  logic [FU_NUM-1:0]            fu_done_i;
  logic [FU_NUM*PW-1:0]         fu_dest_reg_i;
  logic [FU_NUM*DEST_SEL_W-1:0] fu_dest_reg_sel_i;
  logic [FU_NUM*XLEN-1:0]       fu_result_i;
  logic                         cdb_stall_i;
  logic [1:0]                   branch_recover_i;
  logic [FU_NUM-1:0]            fu_complete_en_o;
  logic                         cdb_valid_o;
  logic [PW-1:0]                cdb_tag_o;
  logic [XLEN-1:0]              cdb_value_o;
  logic                         cdb_wr_en_o;
`ifdef CDB_STATS_EN
  logic [FU_NUM*STAT_W-1:0]     grant_cnt_o;
  logic [STAT_W-1:0]            conflict_cnt_o;
`endif

  int assertCount = 0;
  int failCount   = 0;

  cdb_arbiter #(
    .FU_NUM(FU_NUM), .XLEN(XLEN), .PREG_IDX_W(PW)
`ifdef CDB_STATS_EN
    , .STAT_W(STAT_W)
`endif
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .fu_done_i         (fu_done_i),
    .fu_dest_reg_i     (fu_dest_reg_i),
    .fu_dest_reg_sel_i (fu_dest_reg_sel_i),
    .fu_result_i       (fu_result_i),
    .cdb_stall_i       (cdb_stall_i),
    .branch_recover_i  (branch_recover_i),
    .fu_complete_en_o  (fu_complete_en_o),
    .cdb_valid_o       (cdb_valid_o),
    .cdb_tag_o         (cdb_tag_o),
    .cdb_value_o       (cdb_value_o),
    .cdb_wr_en_o       (cdb_wr_en_o)
`ifdef CDB_STATS_EN
    , .grant_cnt_o     (grant_cnt_o),
    .conflict_cnt_o    (conflict_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  done;
    logic        stall;
    logic [1:0]  rec;
    logic [3:0]  expGnt;
    logic        expValid;
    logic [5:0]  expTag;
    logic [31:0] expValue;
    logic        expWrEn;
  } vec_t;

  vec_t vecs [18];

  task automatic applyStimulus(input logic [3:0] done, input logic stall, input logic [1:0] rec);
    fu_done_i        = done;
    cdb_stall_i      = stall;
    branch_recover_i = rec;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic setVec(input int i, input logic [3:0] done, input logic stall, input logic [1:0] rec,
                        input logic [3:0] g, input logic v, input logic [5:0] t,
                        input logic [31:0] val, input logic w);
    vecs[i].done = done;  vecs[i].stall = stall;  vecs[i].rec = rec;
    vecs[i].expGnt = g;   vecs[i].expValid = v;   vecs[i].expTag = t;
    vecs[i].expValue = val; vecs[i].expWrEn = w;
  endtask

  int tally [FU_NUM];

  initial begin
    // FU0 tag5/0x11, FU1 tag7/0x22, FU2 tag0/0x33 (no dest), FU3 tag9/0x44
    fu_dest_reg_i     = {6'd9, 6'd0, 6'd7, 6'd5};
    fu_result_i       = {32'h44, 32'h33, 32'h22, 32'h11};
    fu_dest_reg_sel_i = {DEST_RD, DEST_NONE, DEST_RD, DEST_RD};

    //          idx done    st  rec    gnt     v  tag    value   wr
    setVec( 0, 4'b0101, 0, 2'b00, 4'b0001, 1, 6'd5, 32'h11, 1);
    setVec( 1, 4'b1000, 0, 2'b00, 4'b1000, 1, 6'd9, 32'h44, 1);
    setVec( 2, 4'b1111, 0, 2'b00, 4'b0001, 1, 6'd5, 32'h11, 1);
    setVec( 3, 4'b1111, 0, 2'b00, 4'b0010, 1, 6'd7, 32'h22, 1);
    setVec( 4, 4'b1111, 0, 2'b00, 4'b0100, 1, 6'd0, 32'h33, 0);
    setVec( 5, 4'b1111, 0, 2'b00, 4'b1000, 1, 6'd9, 32'h44, 1);
    setVec( 6, 4'b1111, 0, 2'b00, 4'b0001, 1, 6'd5, 32'h11, 1);
    setVec( 7, 4'b0100, 0, 2'b00, 4'b0100, 1, 6'd0, 32'h33, 0);
    setVec( 8, 4'b1001, 0, 2'b00, 4'b1000, 1, 6'd9, 32'h44, 1);
    setVec( 9, 4'b1001, 0, 2'b00, 4'b0001, 1, 6'd5, 32'h11, 1);
    setVec(10, 4'b0010, 0, 2'b01, 4'b0000, 0, 6'd5, 32'h11, 0);
    setVec(11, 4'b0010, 1, 2'b00, 4'b0000, 0, 6'd5, 32'h11, 0);
    setVec(12, 4'b1111, 1, 2'b01, 4'b0000, 0, 6'd5, 32'h11, 0);
    setVec(13, 4'b0010, 0, 2'b00, 4'b0010, 1, 6'd7, 32'h22, 1);
    setVec(14, 4'b0000, 0, 2'b00, 4'b0000, 0, 6'd7, 32'h22, 0);
    setVec(15, 4'b0001, 0, 2'b10, 4'b0001, 1, 6'd5, 32'h11, 1);
    setVec(16, 4'b1100, 0, 2'b00, 4'b0100, 1, 6'd0, 32'h33, 0);
    setVec(17, 4'b0101, 0, 2'b00, 4'b0001, 1, 6'd5, 32'h11, 1);

    // Reset with every FU requesting: nothing may be granted.
    reset = 1'b1;
    applyStimulus(4'b1111, 1'b0, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset grant", 64'(fu_complete_en_o), 64'h0);
    checkOutput("reset valid", 64'(cdb_valid_o), 64'h0);
    checkOutput("reset tag",   64'(cdb_tag_o),   64'h0);
    checkOutput("reset value", 64'(cdb_value_o), 64'h0);
    checkOutput("reset wr_en", 64'(cdb_wr_en_o), 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].done, vecs[i].stall, vecs[i].rec);
      @(negedge clk);
      checkOutput($sformatf("vec%0d grant", i), 64'(fu_complete_en_o), 64'(vecs[i].expGnt));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d valid", i), 64'(cdb_valid_o), 64'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d tag", i),   64'(cdb_tag_o),   64'(vecs[i].expTag));
      checkOutput($sformatf("vec%0d value", i), 64'(cdb_value_o), 64'(vecs[i].expValue));
      checkOutput($sformatf("vec%0d wr_en", i), 64'(cdb_wr_en_o), 64'(vecs[i].expWrEn));
    end

    // Fairness: all FUs held done, each must win exactly once in FU_NUM cycles.
    for (int f = 0; f < FU_NUM; f++) tally[f] = 0;
    applyStimulus(4'b1111, 1'b0, 2'b00);
    for (int c = 0; c < FU_NUM; c++) begin
      @(negedge clk);
      for (int f = 0; f < FU_NUM; f++) if (fu_complete_en_o[f]) tally[f]++;
    end
    for (int f = 0; f < FU_NUM; f++)
      checkOutput($sformatf("fair FU%0d", f), 64'(tally[f]), 64'd1);
    @(posedge clk);
    #1;

    // Reset lands on the cycle after a grant: the broadcast must not survive.
    applyStimulus(4'b0001, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("pre-reset valid", 64'(cdb_valid_o), 64'h1);
    reset = 1'b1;
    applyStimulus(4'b1111, 1'b0, 2'b00);
    @(negedge clk);
    checkOutput("mid-reset grant", 64'(fu_complete_en_o), 64'h0);
    @(posedge clk);
    #1;
    checkOutput("mid-reset valid", 64'(cdb_valid_o), 64'h0);
    checkOutput("mid-reset tag",   64'(cdb_tag_o),   64'h0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post-reset grant", 64'(fu_complete_en_o), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("post-reset tag", 64'(cdb_tag_o), 64'd5);

`ifdef CDB_STATS_EN
    reset = 1'b1;
    applyStimulus(4'b0000, 1'b0, 2'b00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(4'b0011, 1'b0, 2'b00);
    repeat (10) @(posedge clk);
    #1;
    applyStimulus(4'b0000, 1'b0, 2'b00);
    checkOutput("stats FU0",      64'(grant_cnt_o[0*STAT_W +: STAT_W]), 64'd5);
    checkOutput("stats FU1",      64'(grant_cnt_o[1*STAT_W +: STAT_W]), 64'd5);
    checkOutput("stats FU2",      64'(grant_cnt_o[2*STAT_W +: STAT_W]), 64'd0);
    checkOutput("stats conflict", 64'(conflict_cnt_o), 64'd10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("stats clr FU0",      64'(grant_cnt_o[0*STAT_W +: STAT_W]), 64'd0);
    checkOutput("stats clr FU1",      64'(grant_cnt_o[1*STAT_W +: STAT_W]), 64'd0);
    checkOutput("stats clr conflict", 64'(conflict_cnt_o), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
